instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/loader_pkg.sv | 47 ++++
 rtl/instr_encoder.sv | 57 +++++
 rtl/instr_loader.sv | 140 ++++++++++++++
 tb/tb_instr_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : loader_pkg
// Brief   : Shared instruction-select enumeration, opcode/funct constants and
//           loader FSM state type for the instruction loader.
// Rev     : 1.0  initial release
// ============================================================================
package loader_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
        OP_SLT  = 5'd4,  OP_SGT  = 5'd5,  OP_NOR  = 5'd6,  OP_XOR  = 5'd7,
        OP_SLL  = 5'd8,  OP_SRL  = 5'd9,  OP_JR   = 5'd10, OP_ADDI = 5'd11,
        OP_LW   = 5'd12, OP_SW   = 5'd13, OP_BEQ  = 5'd14, OP_BNE  = 5'd15,
        OP_JAL  = 5'd16, OP_ORI  = 5'd17, OP_XORI = 5'd18
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [5:0] c_opc_rtype = 6'h00;
    localparam logic [5:0] c_opc_jal   = 6'h03;
    localparam logic [5:0] c_opc_addi  = 6'h08;
    localparam logic [5:0] c_opc_lw    = 6'h23;
    localparam logic [5:0] c_opc_sw    = 6'h2B;
    localparam logic [5:0] c_opc_beq   = 6'h04;
    localparam logic [5:0] c_opc_bne   = 6'h05;
    localparam logic [5:0] c_opc_ori   = 6'h0D;
    localparam logic [5:0] c_opc_xori  = 6'h16;

    localparam logic [5:0] c_funct_add = 6'h20;
    localparam logic [5:0] c_funct_sub = 6'h22;
    localparam logic [5:0] c_funct_and = 6'h24;
    localparam logic [5:0] c_funct_or  = 6'h25;
    localparam logic [5:0] c_funct_slt = 6'h2A;
    localparam logic [5:0] c_funct_sgt = 6'h14;
    localparam logic [5:0] c_funct_sll = 6'h00;
    localparam logic [5:0] c_funct_srl = 6'h02;
    localparam logic [5:0] c_funct_nor = 6'h27;
    localparam logic [5:0] c_funct_xor = 6'h15;
    localparam logic [5:0] c_funct_jr  = 6'h08;

endpackage
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module  : instr_encoder
// Brief   : Combinational field packer: op_sel plus operand fields to a 32-bit
//           instruction word, with a flag for unsupported op_sel values.
// Rev     : 1.0  initial release
// ============================================================================
module instr_encoder
    import loader_pkg::*;
(
    input  logic [4:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    function automatic logic [31:0] f_rtype(
        input logic [4:0] f_rs, input logic [4:0] f_rt, input logic [4:0] f_rd,
        input logic [4:0] f_sh, input logic [5:0] f_funct);
        return {c_opc_rtype, f_rs, f_rt, f_rd, f_sh, f_funct};
    endfunction

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_sel)
            OP_ADD:  word = f_rtype(rs, rt, rd, shamt, c_funct_add);
            OP_SUB:  word = f_rtype(rs, rt, rd, shamt, c_funct_sub);
            OP_AND:  word = f_rtype(rs, rt, rd, shamt, c_funct_and);
            OP_OR:   word = f_rtype(rs, rt, rd, shamt, c_funct_or);
            OP_SLT:  word = f_rtype(rs, rt, rd, shamt, c_funct_slt);
            OP_SGT:  word = f_rtype(rs, rt, rd, shamt, c_funct_sgt);
            OP_NOR:  word = f_rtype(rs, rt, rd, shamt, c_funct_nor);
            OP_XOR:  word = f_rtype(rs, rt, rd, shamt, c_funct_xor);
            // Shifts take their source from rt; rs is unused and must read 0.
            OP_SLL:  word = f_rtype(5'd0, rt, rd, shamt, c_funct_sll);
            OP_SRL:  word = f_rtype(5'd0, rt, rd, shamt, c_funct_srl);
            OP_JR:   word = f_rtype(rs, 5'd0, 5'd0, 5'd0, c_funct_jr);
            OP_ADDI: word = {c_opc_addi, rs, rt, imm};
            OP_LW:   word = {c_opc_lw,   rs, rt, imm};
            OP_SW:   word = {c_opc_sw,   rs, rt, imm};
            OP_BEQ:  word = {c_opc_beq,  rs, rt, imm};
            OP_BNE:  word = {c_opc_bne,  rs, rt, imm};
            OP_ORI:  word = {c_opc_ori,  rs, rt, imm};
            OP_XORI: word = {c_opc_xori, rs, rt, imm};
            OP_JAL:  word = {c_opc_jal, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module  : instr_loader
// Brief   : Loads encoded instructions into instruction memory, one word per
//           accepted command, holding the CPU until the session completes.
// Rev     : 1.0  initial release
// ============================================================================
module instr_loader
    import loader_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_finish;
    logic                r_ovf;
    logic                r_in_ready;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
    logic                r_hold;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W:0]     r_count;

    logic [31:0]         w_word;
    logic                w_illegal;
    logic                w_accept;
    logic                w_at_end;

    instr_encoder u_encoder (
        .op_sel  (op_sel),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .imm     (imm),
        .target  (target),
        .word    (w_word),
        .illegal (w_illegal)
    );

    assign w_accept = in_valid && r_in_ready;
    assign w_at_end = (r_addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= BASE_ADDR;
            r_finish   <= 1'b0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= BASE_ADDR;
            r_wr_data  <= '0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_addr     <= BASE_ADDR;
                        r_count    <= '0;
                        r_err      <= 1'b0;
                        r_done     <= 1'b0;
                        r_hold     <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_finish   <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (r_finish) begin
                        // The final write is on the bus this cycle; close out after it.
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_hold   <= 1'b0;
                        r_finish <= 1'b0;
                        r_err    <= r_err | r_ovf;
                    end else if (w_accept) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wr_data <= w_word;
                            r_addr    <= r_addr + ADDR_W'(1);
                            r_count   <= r_count + (ADDR_W+1)'(1);
                        end
                        if (in_last || (!w_illegal && w_at_end)) begin
                            r_in_ready <= 1'b0;
                            r_finish   <= 1'b1;
                            r_ovf      <= !in_last && !w_illegal && w_at_end;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A write registered just before reset is suppressed during the reset cycle.
    assign wr_en      = r_wr_en & ~rst;
    assign in_ready   = r_in_ready;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_loader
// Brief   : Directed self-checking bench for instr_loader (8-bit and 2-bit
//           address instances).
// Rev     : 1.0  initial release
// ============================================================================
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst, start, start2, in_valid, in_last;
    logic [4:0]  op_sel, rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;

    logic        in_ready, wr_en, cpu_hold, done, err;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [8:0]  word_count;

    logic        in_ready2, wr_en2, cpu_hold2, done2, err2;
    logic [1:0]  wr_addr2;
    logic [31:0] wr_data2;
    logic [2:0]  word_count2;

    int checks = 0;
    int errors = 0;
    logic ready2_seen;

    always #5 clk = ~clk;

    instr_loader #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
    );

    instr_loader #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_last(in_last), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .cpu_hold(cpu_hold2), .done(done2), .err(err2), .word_count(word_count2)
    );

    typedef struct {
        logic [4:0]  op, rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] word;
        logic        ill;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one command on the falling edge and return just after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] d, input logic [15:0] im,
                        input logic [25:0] tg, input logic last);
        @(negedge clk);
        op_sel = op; rs = a; rt = b; rd = c; shamt = d; imm = im; target = tg;
        in_last = last; in_valid = 1'b1;
        ready2_seen = in_ready2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0; start2 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic which2);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        if (which2) start2 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; start2 = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
        check({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
        check({tag, "_wr_addr"},    {24'd0, wr_addr},    32'd0);
        check({tag, "_wr_data"},    wr_data,             32'd0);
        check({tag, "_cpu_hold"},   {31'd0, cpu_hold},   32'd0);
        check({tag, "_done"},       {31'd0, done},       32'd0);
        check({tag, "_err"},        {31'd0, err},        32'd0);
        check({tag, "_word_count"}, {23'd0, word_count}, 32'd0);
    endtask

    initial begin
        int exp_addr, writes, accepted;
        vt[0]  = '{5'd11, 5'd0,  5'd8, 5'd0, 5'd0, 16'h0005, 26'h0,  32'h20080005, 1'b0}; // ADDI
        vt[1]  = '{5'd0,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0,    26'h0,  32'h00221820, 1'b0}; // ADD
        vt[2]  = '{5'd8,  5'd7,  5'd1, 5'd2, 5'd4, 16'h0,    26'h0,  32'h00011100, 1'b0}; // SLL, rs dropped
        vt[3]  = '{5'd18, 5'd1,  5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0,  32'h5822FFFF, 1'b0}; // XORI
        vt[4]  = '{5'd1,  5'd4,  5'd5, 5'd6, 5'd0, 16'h0,    26'h0,  32'h00853022, 1'b0}; // SUB
        vt[5]  = '{5'd2,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0,    26'h0,  32'h00221824, 1'b0}; // AND
        vt[6]  = '{5'd3,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0,    26'h0,  32'h00221825, 1'b0}; // OR
        vt[7]  = '{5'd4,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0,    26'h0,  32'h0022182A, 1'b0}; // SLT
        vt[8]  = '{5'd25, 5'd1,  5'd2, 5'd3, 5'd0, 16'h0,    26'h0,  32'h00000000, 1'b1}; // illegal
        vt[9]  = '{5'd5,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0,    26'h0,  32'h00221814, 1'b0}; // SGT
        vt[10] = '{5'd6,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0,    26'h0,  32'h00221827, 1'b0}; // NOR
        vt[11] = '{5'd7,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0,    26'h0,  32'h00221815, 1'b0}; // XOR
        vt[12] = '{5'd9,  5'd9,  5'd3, 5'd4, 5'd2, 16'h0,    26'h0,  32'h00032082, 1'b0}; // SRL, rs dropped
        vt[13] = '{5'd12, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0010, 26'h0,  32'h8FA80010, 1'b0}; // LW
        vt[14] = '{5'd13, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0010, 26'h0,  32'hAFA80010, 1'b0}; // SW
        vt[15] = '{5'd14, 5'd1,  5'd2, 5'd0, 5'd0, 16'hFFFE, 26'h0,  32'h1022FFFE, 1'b0}; // BEQ
        vt[16] = '{5'd15, 5'd1,  5'd2, 5'd0, 5'd0, 16'hFFFE, 26'h0,  32'h1422FFFE, 1'b0}; // BNE
        vt[17] = '{5'd17, 5'd0,  5'd1, 5'd0, 5'd0, 16'h1234, 26'h0,  32'h34011234, 1'b0}; // ORI
        vt[18] = '{5'd16, 5'd3,  5'd4, 5'd5, 5'd6, 16'h0,    26'h10, 32'h0C000010, 1'b0}; // JAL
        vt[19] = '{5'd10, 5'd31, 5'd5, 5'd5, 5'd3, 16'h0,    26'h0,  32'h03E00008, 1'b0}; // JR, fields dropped

        rst = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        op_sel = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
        ready2_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        rst = 1'b0;
        idle();
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // Session 1: full table back-to-back, illegal op mid-stream, JR last.
        pulse_start(1'b0);
        check("load_in_ready", {31'd0, in_ready}, 32'd1);
        check("load_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        exp_addr = 0;
        for (int i = 0; i < NV; i++) begin
            send(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sh, vt[i].imm, vt[i].tgt, i == NV-1);
            check($sformatf("v%0d_wr_en", i), {31'd0, wr_en}, {31'd0, !vt[i].ill});
            if (vt[i].ill) begin
                check($sformatf("v%0d_err", i), {31'd0, err}, 32'd1);
            end else begin
                check($sformatf("v%0d_wr_data", i), wr_data, vt[i].word);
                check($sformatf("v%0d_wr_addr", i), {24'd0, wr_addr}, exp_addr);
                exp_addr++;
            end
        end
        idle();
        check("s1_done", {31'd0, done}, 32'd1);
        check("s1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("s1_wr_en_clear", {31'd0, wr_en}, 32'd0);
        check("s1_word_count", {23'd0, word_count}, 32'd19);
        check("s1_err_sticky", {31'd0, err}, 32'd1);

        // Session 2: restart from DONE clears err; start during LOAD is ignored.
        pulse_start(1'b0);
        check("s2_err_cleared", {31'd0, err}, 32'd0);
        check("s2_done_cleared", {31'd0, done}, 32'd0);
        check("s2_count_cleared", {23'd0, word_count}, 32'd0);
        send(5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b0);
        check("s2_jal_word", wr_data, 32'h0C000010);
        check("s2_jal_addr", {24'd0, wr_addr}, 32'd0);
        start = 1'b1;
        send(5'd10, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        start = 1'b0;
        check("s2_jr_word", wr_data, 32'h03E00008);
        check("s2_jr_addr", {24'd0, wr_addr}, 32'd1);
        check("s2_hold_during_write", {31'd0, cpu_hold}, 32'd1);
        idle();
        check("s2_done", {31'd0, done}, 32'd1);
        check("s2_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("s2_word_count", {23'd0, word_count}, 32'd2);
        check("s2_err", {31'd0, err}, 32'd0);

        // Session 3: 2-bit address, five commands, no last -> overflow stop.
        pulse_start(1'b1);
        writes = 0; accepted = 0;
        for (int k = 0; k < 8; k++) begin
            send(5'd11, 5'd0, 5'd1, 5'd0, 5'd0, 16'(k), 26'h0, 1'b0);
            if (k < 5 && ready2_seen) accepted++;
            if (wr_en2) begin
                check($sformatf("ovf_addr%0d", writes), {30'd0, wr_addr2}, writes);
                writes++;
            end
        end
        idle();
        check("ovf_writes", writes, 32'd4);
        check("ovf_accepted", accepted, 32'd4);
        check("ovf_in_ready", {31'd0, in_ready2}, 32'd0);
        check("ovf_done", {31'd0, done2}, 32'd1);
        check("ovf_err", {31'd0, err2}, 32'd1);
        check("ovf_word_count", {29'd0, word_count2}, 32'd4);
        check("ovf_main_untouched", {23'd0, word_count}, 32'd2);

        // Session 4: last command also fills memory -> DONE without err.
        pulse_start(1'b1);
        for (int k = 0; k < 4; k++)
            send(5'd11, 5'd0, 5'd2, 5'd0, 5'd0, 16'(k), 26'h0, k == 3);
        check("fill_last_word", wr_data2, 32'h20020003);
        idle();
        check("fill_last_done", {31'd0, done2}, 32'd1);
        check("fill_last_err", {31'd0, err2}, 32'd0);
        check("fill_last_count", {29'd0, word_count2}, 32'd4);

        // Session 5: reset right after an accept drops the pending write.
        pulse_start(1'b0);
        send(5'd11, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_drop_wr_en", {31'd0, wr_en}, 32'd0);
        @(posedge clk);
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
